// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the default word size, the 2-bit FSM state encoding and the
// requester IDs used by the arbiter and its round-robin tie-breaker.
package mips_pkg;

    localparam int unsigned WORD_SIZE_DEFAULT = 32;

    // Arbiter FSM: idle/arbitrate, read in flight, response cycle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Requester IDs; also the bit index of each requester in the arbiter vectors.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    // Data accesses are whole words only.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the
// single-port RAM.
//   slave  : arbiter view (takes requests and ram_rdata, drives grants,
//            responses and the RAM strobes)
//   master : environment view (requesters plus RAM), the mirror image
interface mem_arbiter_if
    import mips_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT
) ();

    // Fetch port
    logic                 if_req;
    logic [WORD_SIZE-1:0] if_addr;
    logic                 if_gnt;
    logic                 if_rsp_valid;
    logic [WORD_SIZE-1:0] if_rsp_data;

    // Data port
    logic                 dm_req;
    logic                 dm_we;
    logic [WORD_SIZE-1:0] dm_addr;
    logic [WORD_SIZE-1:0] dm_wdata;
    logic                 dm_gnt;
    logic                 dm_err;
    logic                 dm_rsp_valid;
    logic [WORD_SIZE-1:0] dm_rsp_data;

    // Shared RAM port
    logic                 ram_en;
    logic                 ram_we;
    logic [WORD_SIZE-1:0] ram_addr;
    logic [WORD_SIZE-1:0] ram_wdata;
    logic [WORD_SIZE-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rsp_valid, if_rsp_data,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_err, dm_rsp_valid, dm_rsp_data,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rsp_valid, if_rsp_data,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_err, dm_rsp_valid, dm_rsp_data,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-input round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en_i       : grants may be issued this cycle
//   req_i      : eligible requests, indexed by REQ_IF / REQ_DM
//   gnt_o      : one-hot (or zero) grant, same indexing
// On a tie the requester that did not win most recently is granted. The
// pointer resets to REQ_DM so that fetch wins the first tie.
module arb_rr2
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (last_q == REQ_IF) ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
            if (gnt_o[REQ_DM]) begin
                last_d = REQ_DM;
            end else if (gnt_o[REQ_IF]) begin
                last_d = REQ_IF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= REQ_DM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between an instruction-fetch port and
// a data port.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_arbiter_if.slave -- fetch/data request and response
//                handshakes plus the RAM strobes and read data
// Parameters:
//   WORD_SIZE   : data/address width
//   RAM_LATENCY : cycles from read issue to valid ram_rdata (1..4)
// Grants are combinational in IDLE. A store finishes in its grant cycle; a
// read occupies the port for RAM_LATENCY cycles of WAIT plus one RESP cycle.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = WORD_SIZE_DEFAULT,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] LatLoad = 2'(RAM_LATENCY - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;

    logic       arb_en;
    logic       dm_aligned;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;

    assign dm_aligned = is_word_aligned(bus.dm_addr[1:0]);
    assign arb_en     = rst_n && (state_q == StIdle);

    // A misaligned data request is simply not eligible, so it can neither win
    // nor move the round-robin pointer, while fetch stays eligible.
    always_comb begin
        arb_req         = 2'b00;
        arb_req[REQ_IF] = bus.if_req;
        arb_req[REQ_DM] = bus.dm_req && dm_aligned;
    end

    arb_rr2 u_arb_rr2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (arb_en),
        .req_i (arb_req),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        owner_d          = owner_q;
        bus.if_gnt       = 1'b0;
        bus.if_rsp_valid = 1'b0;
        bus.if_rsp_data  = {WORD_SIZE{1'b0}};
        bus.dm_gnt       = 1'b0;
        bus.dm_err       = 1'b0;
        bus.dm_rsp_valid = 1'b0;
        bus.dm_rsp_data  = {WORD_SIZE{1'b0}};
        bus.ram_en       = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_addr     = {WORD_SIZE{1'b0}};
        bus.ram_wdata    = {WORD_SIZE{1'b0}};

        // Outputs stay quiet while reset is asserted.
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    bus.if_gnt = arb_gnt[REQ_IF];
                    bus.dm_gnt = arb_gnt[REQ_DM];
                    bus.dm_err = bus.dm_req && !dm_aligned;
                    if (arb_gnt[REQ_IF]) begin
                        bus.ram_en   = 1'b1;
                        bus.ram_addr = bus.if_addr;
                        state_d      = StWait;
                        cnt_d        = LatLoad;
                        owner_d      = REQ_IF;
                    end else if (arb_gnt[REQ_DM]) begin
                        bus.ram_en   = 1'b1;
                        bus.ram_we   = bus.dm_we;
                        bus.ram_addr = bus.dm_addr;
                        if (bus.dm_we) begin
                            // Store completes now; stay in IDLE.
                            bus.ram_wdata = bus.dm_wdata;
                        end else begin
                            state_d = StWait;
                            cnt_d   = LatLoad;
                            owner_d = REQ_DM;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 2'd0) begin
                        state_d = StResp;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                StResp: begin
                    if (owner_q == REQ_IF) begin
                        bus.if_rsp_valid = 1'b1;
                        bus.if_rsp_data  = bus.ram_rdata;
                    end else begin
                        bus.dm_rsp_valid = 1'b1;
                        bus.dm_rsp_data  = bus.ram_rdata;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            owner_q <= REQ_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM_LATENCY 1 and 3) share a RAM
// model; sel routes the requester stimulus to one of them at a time.
module tb_mem_arbiter;
    import mips_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WORD_SIZE(W)) ifc1 ();
    mem_arbiter_if #(.WORD_SIZE(W)) ifc3 ();

    mem_arbiter #(.WORD_SIZE(W), .RAM_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    mem_arbiter #(.WORD_SIZE(W), .RAM_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(ifc3));

    // Stimulus
    logic         sel = 1'b0;
    logic         d_if_req = 1'b0, d_dm_req = 1'b0, d_dm_we = 1'b0;
    logic [W-1:0] d_if_addr = '0, d_dm_addr = '0, d_dm_wdata = '0;

    assign ifc1.if_req   = d_if_req & ~sel;
    assign ifc1.dm_req   = d_dm_req & ~sel;
    assign ifc3.if_req   = d_if_req & sel;
    assign ifc3.dm_req   = d_dm_req & sel;
    assign ifc1.if_addr  = d_if_addr;
    assign ifc3.if_addr  = d_if_addr;
    assign ifc1.dm_we    = d_dm_we;
    assign ifc3.dm_we    = d_dm_we;
    assign ifc1.dm_addr  = d_dm_addr;
    assign ifc3.dm_addr  = d_dm_addr;
    assign ifc1.dm_wdata = d_dm_wdata;
    assign ifc3.dm_wdata = d_dm_wdata;

    // Observed outputs of the selected instance
    logic         o_if_gnt, o_dm_gnt, o_dm_err, o_ram_en, o_ram_we, o_if_rv, o_dm_rv;
    logic [W-1:0] o_ram_addr, o_ram_wdata, o_if_rd, o_dm_rd;
    assign o_if_gnt    = sel ? ifc3.if_gnt       : ifc1.if_gnt;
    assign o_dm_gnt    = sel ? ifc3.dm_gnt       : ifc1.dm_gnt;
    assign o_dm_err    = sel ? ifc3.dm_err       : ifc1.dm_err;
    assign o_ram_en    = sel ? ifc3.ram_en       : ifc1.ram_en;
    assign o_ram_we    = sel ? ifc3.ram_we       : ifc1.ram_we;
    assign o_ram_addr  = sel ? ifc3.ram_addr     : ifc1.ram_addr;
    assign o_ram_wdata = sel ? ifc3.ram_wdata    : ifc1.ram_wdata;
    assign o_if_rv     = sel ? ifc3.if_rsp_valid : ifc1.if_rsp_valid;
    assign o_if_rd     = sel ? ifc3.if_rsp_data  : ifc1.if_rsp_data;
    assign o_dm_rv     = sel ? ifc3.dm_rsp_valid : ifc1.dm_rsp_valid;
    assign o_dm_rd     = sel ? ifc3.dm_rsp_data  : ifc1.dm_rsp_data;

    // RAM model: word-indexed, read data registered and held until next read
    logic [W-1:0] mem [0:1023];
    logic [W-1:0] rd1;
    logic [W-1:0] rd3 [0:2];
    logic         clr = 1'b0, poke_en = 1'b0;
    logic [9:0]   poke_idx = '0;
    logic [W-1:0] poke_data = '0;

    assign ifc1.ram_rdata = rd1;
    assign ifc3.ram_rdata = rd3[2];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end
        if (poke_en) mem[poke_idx] <= poke_data;
        if (ifc1.ram_en && ifc1.ram_we) mem[ifc1.ram_addr[11:2]] <= ifc1.ram_wdata;
        if (ifc3.ram_en && ifc3.ram_we) mem[ifc3.ram_addr[11:2]] <= ifc3.ram_wdata;
        if (ifc1.ram_en && !ifc1.ram_we) rd1 <= mem[ifc1.ram_addr[11:2]];
        if (ifc3.ram_en && !ifc3.ram_we) rd3[0] <= mem[ifc3.ram_addr[11:2]];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    // Expected memory contents
    logic [W-1:0] ref_mem [0:1023];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drain();
        tick();
        d_if_req = 1'b0;
        d_dm_req = 1'b0;
        repeat (6) tick();
    endtask

    task automatic poke(input int idx, input logic [W-1:0] data);
        poke_en   = 1'b1;
        poke_idx  = 10'(idx);
        poke_data = data;
        ref_mem[idx] = data;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_n = 1'b0;
        d_if_req = 1'b1; d_if_addr = 32'h100;
        d_dm_req = 1'b1; d_dm_we = 1'b0; d_dm_addr = 32'h102;
        for (int c = 0; c < 2; c++) begin
            smp();
            checks++;
            if ({o_if_gnt, o_dm_gnt, o_dm_err, o_ram_en, o_if_rv, o_dm_rv} !== 6'b0) begin
                errors++;
                $display("FAIL reset_strobes got %b want 000000",
                         {o_if_gnt, o_dm_gnt, o_dm_err, o_ram_en, o_if_rv, o_dm_rv});
            end
            checks++;
            if (o_ram_addr !== '0) begin
                errors++; $display("FAIL reset_ram_addr got %h want 0", o_ram_addr);
            end
            tick();
        end
    endtask

    task automatic test_tie();
        rst_n = 1'b1;
        d_if_req = 1'b1; d_if_addr = 32'h100;
        d_dm_req = 1'b1; d_dm_we = 1'b0; d_dm_addr = 32'h100;
        smp();
        checks++;
        if (o_if_gnt !== 1'b1 || o_dm_gnt !== 1'b0) begin
            errors++; $display("FAIL tie_first got if=%b dm=%b want if=1 dm=0", o_if_gnt, o_dm_gnt);
        end
        checks++;
        if (o_ram_en !== 1'b1 || o_ram_we !== 1'b0 || o_ram_addr !== 32'h100) begin
            errors++;
            $display("FAIL tie_ram got en=%b we=%b addr=%h want 1 0 100", o_ram_en, o_ram_we, o_ram_addr);
        end
        tick(); d_if_req = 1'b0; smp();
        checks++;
        if (o_dm_gnt !== 1'b0 || o_if_rv !== 1'b0 || o_ram_en !== 1'b0) begin
            errors++; $display("FAIL tie_wait got gnt=%b rv=%b en=%b want 000", o_dm_gnt, o_if_rv, o_ram_en);
        end
        tick(); smp();
        checks++;
        if (o_if_rv !== 1'b1 || o_if_rd !== 32'hDEADBEEF || o_dm_gnt !== 1'b0) begin
            errors++;
            $display("FAIL tie_if_rsp got v=%b d=%h g=%b want 1 deadbeef 0", o_if_rv, o_if_rd, o_dm_gnt);
        end
        tick(); smp();
        checks++;
        if (o_dm_gnt !== 1'b1 || o_if_gnt !== 1'b0 || o_ram_addr !== 32'h100) begin
            errors++;
            $display("FAIL tie_dm_gnt got dm=%b if=%b addr=%h want 1 0 100", o_dm_gnt, o_if_gnt, o_ram_addr);
        end
        tick(); d_dm_req = 1'b0; smp();
        tick(); smp();
        checks++;
        if (o_dm_rv !== 1'b1 || o_dm_rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL tie_dm_rsp got v=%b d=%h want 1 deadbeef", o_dm_rv, o_dm_rd);
        end
        tick();
    endtask

    task automatic test_store();
        tick();
        d_dm_req = 1'b1; d_dm_we = 1'b1; d_dm_addr = 32'h20; d_dm_wdata = 32'h12345678;
        smp();
        checks++;
        if (o_dm_gnt !== 1'b1 || o_ram_en !== 1'b1 || o_ram_we !== 1'b1 || o_ram_addr !== 32'h20
            || o_ram_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL store_grant got g=%b en=%b we=%b a=%h d=%h want 1 1 1 20 12345678",
                     o_dm_gnt, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata);
        end
        ref_mem[8] = 32'h12345678;
        tick();
        d_dm_req = 1'b0; d_dm_we = 1'b0; d_if_req = 1'b1; d_if_addr = 32'h20;
        smp();
        checks++;
        if (o_if_gnt !== 1'b1 || o_dm_rv !== 1'b0 || o_ram_we !== 1'b0 || o_ram_wdata !== '0) begin
            errors++;
            $display("FAIL store_next got g=%b rv=%b we=%b wd=%h want 1 0 0 0",
                     o_if_gnt, o_dm_rv, o_ram_we, o_ram_wdata);
        end
        tick(); d_if_req = 1'b0; smp();
        tick(); smp();
        checks++;
        if (o_if_rv !== 1'b1 || o_if_rd !== 32'h12345678 || o_dm_rv !== 1'b0) begin
            errors++;
            $display("FAIL store_readback got v=%b d=%h dv=%b want 1 12345678 0", o_if_rv, o_if_rd, o_dm_rv);
        end
        tick();
    endtask

    task automatic test_misaligned();
        tick();
        d_dm_req = 1'b1; d_dm_we = 1'b0; d_dm_addr = 32'h22;
        smp();
        checks++;
        if (o_dm_err !== 1'b1 || o_dm_gnt !== 1'b0 || o_ram_en !== 1'b0) begin
            errors++;
            $display("FAIL misalign_err got err=%b g=%b en=%b want 1 0 0", o_dm_err, o_dm_gnt, o_ram_en);
        end
        // Pointer must still favour data after the rejected request.
        tick();
        d_dm_addr = 32'h24; d_if_req = 1'b1; d_if_addr = 32'h30;
        smp();
        checks++;
        if (o_dm_gnt !== 1'b1 || o_if_gnt !== 1'b0 || o_dm_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_ptr got dm=%b if=%b err=%b want 1 0 0", o_dm_gnt, o_if_gnt, o_dm_err);
        end
        tick(); d_dm_req = 1'b0; smp();
        tick(); smp();
        checks++;
        if (o_dm_rv !== 1'b1 || o_if_gnt !== 1'b0) begin
            errors++; $display("FAIL misalign_busy got rv=%b ifg=%b want 1 0", o_dm_rv, o_if_gnt);
        end
        // Fetch stays eligible while data errors; fetch address passes unmodified.
        tick();
        d_dm_req = 1'b1; d_dm_addr = 32'h33; d_if_addr = 32'h31;
        smp();
        checks++;
        if (o_dm_err !== 1'b1 || o_if_gnt !== 1'b1 || o_dm_gnt !== 1'b0 || o_ram_addr !== 32'h31) begin
            errors++;
            $display("FAIL misalign_fetch got err=%b ifg=%b dmg=%b a=%h want 1 1 0 31",
                     o_dm_err, o_if_gnt, o_dm_gnt, o_ram_addr);
        end
        drain();
    endtask

    task automatic test_alternate();
        logic exp_dm;
        int   n;
        exp_dm = 1'b1;
        n = 0;
        tick();
        d_if_req = 1'b1; d_if_addr = 32'h100;
        d_dm_req = 1'b1; d_dm_we = 1'b0; d_dm_addr = 32'h104;
        for (int c = 0; c < 100 && n < 10; c++) begin
            smp();
            checks++;
            if (o_if_gnt && o_dm_gnt) begin
                errors++; $display("FAIL alt_both cyc %0d got both grants want at most one", c);
            end
            if (o_if_gnt || o_dm_gnt) begin
                checks++;
                if (o_dm_gnt !== exp_dm) begin
                    errors++; $display("FAIL alt_order grant %0d got dm=%b want dm=%b", n, o_dm_gnt, exp_dm);
                end
                exp_dm = ~exp_dm;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 10) begin
            errors++; $display("FAIL alt_count got %0d grants want 10", n);
        end
        d_if_req = 1'b0; d_dm_req = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_latency3();
        tick();
        sel = 1'b1;
        d_if_req = 1'b1; d_if_addr = 32'h40; d_dm_req = 1'b0;
        smp();
        checks++;
        if (o_if_gnt !== 1'b1 || o_ram_addr !== 32'h40) begin
            errors++; $display("FAIL lat3_gnt got g=%b a=%h want 1 40", o_if_gnt, o_ram_addr);
        end
        tick();
        d_if_req = 1'b0; d_dm_req = 1'b1; d_dm_we = 1'b0; d_dm_addr = 32'h44;
        for (int k = 1; k <= 3; k++) begin
            smp();
            checks++;
            if (o_dm_gnt !== 1'b0 || o_if_rv !== 1'b0) begin
                errors++; $display("FAIL lat3_wait cyc %0d got g=%b rv=%b want 0 0", k, o_dm_gnt, o_if_rv);
            end
            tick();
        end
        smp();
        checks++;
        if (o_if_rv !== 1'b1 || o_if_rd !== 32'h0BADF00D || o_dm_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lat3_rsp got v=%b d=%h g=%b want 1 0badf00d 0", o_if_rv, o_if_rd, o_dm_gnt);
        end
        tick(); smp();
        checks++;
        if (o_dm_gnt !== 1'b1) begin
            errors++; $display("FAIL lat3_dm_after got %b want 1", o_dm_gnt);
        end
        drain();
    endtask

    task automatic test_reset_in_wait();
        tick();
        sel = 1'b1; d_if_req = 1'b1; d_if_addr = 32'h40;
        smp();
        checks++;
        if (o_if_gnt !== 1'b1) begin
            errors++; $display("FAIL rstwait_gnt got %b want 1", o_if_gnt);
        end
        tick(); d_if_req = 1'b0; rst_n = 1'b0;
        smp();
        checks++;
        if (o_if_rv !== 1'b0 || o_ram_en !== 1'b0) begin
            errors++; $display("FAIL rstwait_in_rst got rv=%b en=%b want 0 0", o_if_rv, o_ram_en);
        end
        tick();
        tick();
        rst_n = 1'b1;
        d_if_req = 1'b1; d_dm_req = 1'b1; d_dm_we = 1'b0; d_dm_addr = 32'h48;
        smp();
        checks++;
        if (o_if_gnt !== 1'b1 || o_dm_gnt !== 1'b0 || o_if_rv !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_tie got if=%b dm=%b rv=%b want 1 0 0", o_if_gnt, o_dm_gnt, o_if_rv);
        end
        tick(); d_if_req = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            smp();
            checks++;
            if (o_if_rv !== 1'b0) begin
                errors++; $display("FAIL rstwait_stale cyc %0d got rv=%b want 0", k, o_if_rv);
            end
            tick();
        end
        smp();
        checks++;
        if (o_if_rv !== 1'b1 || o_if_rd !== 32'h0BADF00D) begin
            errors++; $display("FAIL rstwait_new got v=%b d=%h want 1 0badf00d", o_if_rv, o_if_rd);
        end
        drain();
    endtask

    // Reference: the port is busy for lat+1 cycles after a read grant and the
    // response lands in the last of them; stores cost nothing extra.
    task automatic test_random(input int lat, input logic which);
        int           busy;
        logic         last, owner, a_if, a_dm, g_if, g_dm, dm_ok, win_if, win_dm;
        logic [W-1:0] if_a, dm_a, dm_wd, exp_data;
        logic         dm_w;
        logic         e_ifg, e_dmg, e_err, e_en, e_we, e_ifv, e_dmv;
        logic [W-1:0] e_addr, e_wd, e_ifd, e_dmd;
        busy = 0; last = REQ_DM; owner = REQ_IF; exp_data = '0;
        a_if = 1'b0; a_dm = 1'b0; g_if = 1'b0; g_dm = 1'b0;
        if_a = '0; dm_a = '0; dm_wd = '0; dm_w = 1'b0;
        tick();
        sel = which; rst_n = 1'b0; d_if_req = 1'b0; d_dm_req = 1'b0;
        tick();
        for (int c = 0; c < 300; c++) begin
            tick();
            rst_n = 1'b1;
            if (g_if) a_if = 1'b0;
            if (g_dm) a_dm = 1'b0;
            if (!a_if && $urandom_range(0, 1) == 1) begin
                a_if = 1'b1;
                if_a = 32'($urandom_range(0, 255));
            end
            if (!a_dm && $urandom_range(0, 1) == 1) begin
                a_dm  = 1'b1;
                dm_w  = 1'($urandom_range(0, 1));
                dm_a  = 32'($urandom_range(0, 15)) << 2;
                if ($urandom_range(0, 3) == 0) dm_a[1:0] = 2'($urandom_range(1, 3));
                dm_wd = $urandom;
            end
            d_if_req = a_if; d_if_addr = if_a;
            d_dm_req = a_dm; d_dm_we = dm_w; d_dm_addr = dm_a; d_dm_wdata = dm_wd;
            smp();
            {e_ifg, e_dmg, e_err, e_en, e_we, e_ifv, e_dmv} = '0;
            e_addr = '0; e_wd = '0; e_ifd = '0; e_dmd = '0;
            if (busy == 0) begin
                dm_ok  = a_dm && (dm_a[1:0] == 2'b00);
                e_err  = a_dm && !dm_ok;
                win_dm = (a_if && dm_ok) ? (last == REQ_IF) : dm_ok;
                win_if = a_if && !win_dm;
                if (win_if) begin
                    e_ifg = 1'b1; e_en = 1'b1; e_addr = if_a;
                    busy = lat + 1; owner = REQ_IF; last = REQ_IF;
                    exp_data = ref_mem[if_a[11:2]];
                end else if (win_dm) begin
                    e_dmg = 1'b1; e_en = 1'b1; e_we = dm_w; e_addr = dm_a; last = REQ_DM;
                    if (dm_w) begin
                        e_wd = dm_wd;
                        ref_mem[dm_a[11:2]] = dm_wd;
                    end else begin
                        busy = lat + 1; owner = REQ_DM;
                        exp_data = ref_mem[dm_a[11:2]];
                    end
                end
            end else begin
                if (busy == 1) begin
                    if (owner == REQ_IF) begin
                        e_ifv = 1'b1; e_ifd = exp_data;
                    end else begin
                        e_dmv = 1'b1; e_dmd = exp_data;
                    end
                end
                busy--;
            end
            g_if = e_ifg;
            g_dm = e_dmg || e_err;
            checks++;
            if ({o_if_gnt, o_dm_gnt, o_dm_err} !== {e_ifg, e_dmg, e_err}) begin
                errors++;
                $display("FAIL rnd_grants lat %0d cyc %0d got ifg/dmg/err=%b want %b", lat, c,
                         {o_if_gnt, o_dm_gnt, o_dm_err}, {e_ifg, e_dmg, e_err});
            end
            checks++;
            if ({o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata} !== {e_en, e_we, e_addr, e_wd}) begin
                errors++;
                $display("FAIL rnd_ram lat %0d cyc %0d got en=%b we=%b a=%h d=%h want %b %b %h %h",
                         lat, c, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, e_en, e_we, e_addr, e_wd);
            end
            checks++;
            if ({o_if_rv, o_if_rd, o_dm_rv, o_dm_rd} !== {e_ifv, e_ifd, e_dmv, e_dmd}) begin
                errors++;
                $display("FAIL rnd_rsp lat %0d cyc %0d got if=%b/%h dm=%b/%h want if=%b/%h dm=%b/%h",
                         lat, c, o_if_rv, o_if_rd, o_dm_rv, o_dm_rd, e_ifv, e_ifd, e_dmv, e_dmd);
            end
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst_n = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        poke(64, 32'hDEADBEEF);
        poke(16, 32'h0BADF00D);
        test_reset();
        test_tie();
        test_store();
        test_misaligned();
        test_alternate();
        test_latency3();
        test_reset_in_wait();
        test_random(1, 1'b0);
        test_random(3, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
